// File: rtl/riscv_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC sequencer for the minimal RV32 core (ADDI, optional BNE).
// Define RISCV_SEQ_BNE_EN to decode and execute BNE; otherwise BRANCH is illegal.
module riscv_seq_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted,
    output logic [1:0]      fault
);

    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_imem_req;
    logic            r_halted;
    logic [1:0]      r_fault;
    logic            r_is_bne;

    logic            w_dec_addi;
    logic            w_dec_bne;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_target;
    logic            w_br_misaligned;
    logic            w_exec;

    assign w_dec_addi = (r_instr[1:0] == 2'b11) && (r_instr[6:2] == OPC_OPIMM)
                        && (r_instr[14:12] == F3_ADDI);
    assign w_imm_i    = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_pc_plus4 = r_pc + XLEN'(4);

`ifdef RISCV_SEQ_BNE_EN
    logic [XLEN-1:0] w_imm_b;

    assign w_dec_bne = (r_instr[1:0] == 2'b11) && (r_instr[6:2] == OPC_BRANCH)
                       && (r_instr[14:12] == F3_BNE);
    assign w_imm_b   = {{(XLEN-13){r_instr[31]}}, r_instr[31], r_instr[7],
                        r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_br_target     = (rf_rdata1 != rf_rdata2) ? (r_pc + w_imm_b) : w_pc_plus4;
    assign w_br_misaligned = w_br_target[1];
`else
    logic w_unused_rdata2;

    assign w_dec_bne       = 1'b0;
    assign w_br_target     = w_pc_plus4;
    assign w_br_misaligned = 1'b0;
    assign w_unused_rdata2 = ^rf_rdata2;
`endif

    // EXEC-cycle strobes are decoded from state because the write data depends on
    // the combinational register-file read in that same cycle.
    assign w_exec   = (r_state == S_EXEC);
    assign rf_we    = w_exec && !r_is_bne && (r_instr[11:7] != 5'd0);
    assign retire   = w_exec && !(r_is_bne && w_br_misaligned);
    assign rf_wdata = rf_rdata1 + w_imm_i;
    assign rf_waddr = r_instr[11:7];

    assign rf_raddr1 = r_instr[19:15];
    assign rf_raddr2 = r_instr[24:20];
    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign fault     = r_fault;

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking assignments would make results order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 2'b00;
            r_is_bne   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // The first FETCH cycle after reset only raises the request.
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_dec_addi || w_dec_bne) begin
                        r_is_bne <= w_dec_bne;
                        r_state  <= S_EXEC;
                    end else begin
                        r_halted <= 1'b1;
                        r_fault  <= FAULT_ILLEGAL;
                        r_state  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (r_is_bne && w_br_misaligned) begin
                        r_halted <= 1'b1;
                        r_fault  <= FAULT_MISALIGN;
                        r_state  <= S_HALT;
                    end else begin
                        r_pc       <= r_is_bne ? w_br_target : w_pc_plus4;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Directed bench for riscv_seq_ctrl: instruction memory with programmable ack delay and a register-file model.
module tb_riscv_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        retire;
    logic        halted;
    logic [1:0]  fault;

    logic [31:0] mem  [0:15];
    logic [31:0] regs [0:31];
    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit manual = 1'b0;

    riscv_seq_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .retire(retire), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Memory responder: acks after ack_delay wait cycles of a held request.
    always @(negedge clk) begin
        if (!manual) begin
            if (imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr[5:2]];
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_retire(output bit ok, output int cyc, output logic we,
                               output logic [4:0] wa, output logic [31:0] wd);
        ok = 1'b0; cyc = 0; we = 1'b0; wa = '0; wd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (retire) begin
                ok = 1'b1; cyc = i; we = rf_we; wa = rf_waddr; wd = rf_wdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ack_delay = 0;
        clear_mem();
        mem[0] = 32'h0050_0093;
        do_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (halted !== 1'b0 || fault !== 2'b00) begin errors++; $display("FAIL reset_halt got %b/%b want 0/00", halted, fault); end
        checks++; if (retire !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b/%b want 0/0", retire, rf_we); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL req_rise got %b@%h want 1@00000000", imem_req, imem_addr); end
    endtask

    task automatic test_addi_chain();
        bit ok; int cyc; logic we; logic [4:0] wa; logic [31:0] wd;
        ack_delay = 0;
        clear_mem();
        mem[0] = 32'h0050_0093;   // addi x1,x0,5
        mem[1] = 32'hFF90_8113;   // addi x2,x1,-7
        do_reset();
        wait_retire(ok, cyc, we, wa, wd);
        checks++; if (!ok || cyc != 3) begin errors++; $display("FAIL addi1_latency got ok=%0d cyc=%0d want ok=1 cyc=3", ok, cyc); end
        checks++; if ({we, wa, wd} !== {1'b1, 5'd1, 32'd5}) begin errors++; $display("FAIL addi1_write got we=%b rd=%0d d=%h want 1 1 00000005", we, wa, wd); end
        wait_retire(ok, cyc, we, wa, wd);
        checks++; if (!ok || cyc != 3) begin errors++; $display("FAIL addi2_latency got ok=%0d cyc=%0d want ok=1 cyc=3", ok, cyc); end
        checks++; if ({we, wa, wd} !== {1'b1, 5'd2, 32'hFFFF_FFFE}) begin errors++; $display("FAIL addi2_write got we=%b rd=%0d d=%h want 1 2 fffffffe", we, wa, wd); end
        @(negedge clk);
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL addi_pc got %h want 00000008", pc); end
        checks++; if (regs[2] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL addi_x2 got %h want fffffffe", regs[2]); end
    endtask

    task automatic test_addi_x0();
        bit ok; int cyc; logic we; logic [4:0] wa; logic [31:0] wd;
        ack_delay = 0;
        clear_mem();
        mem[0] = 32'h0010_0013;   // addi x0,x0,1
        do_reset();
        wait_retire(ok, cyc, we, wa, wd);
        checks++; if (!ok || we !== 1'b0) begin errors++; $display("FAIL x0_write got ok=%0d we=%b want ok=1 we=0", ok, we); end
        @(negedge clk);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL x0_pc got %h want 00000004", pc); end
    endtask

    task automatic test_illegal(input logic [31:0] word, input string name);
        bit saw_retire = 1'b0; int halt_cyc = 0; bit req_seen = 1'b0;
        ack_delay = 0;
        clear_mem();
        mem[0] = word;
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (retire) saw_retire = 1'b1;
            if (halted && halt_cyc == 0) halt_cyc = i;
            if (halt_cyc != 0 && imem_req) req_seen = 1'b1;
        end
        checks++; if (halt_cyc != 3) begin errors++; $display("FAIL %s_halt_cycle got %0d want 3", name, halt_cyc); end
        checks++; if (halted !== 1'b1 || fault !== 2'b01) begin errors++; $display("FAIL %s_fault got %b/%b want 1/01", name, halted, fault); end
        checks++; if (saw_retire || req_seen) begin errors++; $display("FAIL %s_quiet got retire=%0d req=%0d want 0/0", name, saw_retire, req_seen); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL %s_pc got %h want 00000000", name, pc); end
    endtask

    task automatic load_branch_prog(input logic [31:0] x2_init, input logic [31:0] bne_word);
        clear_mem();
        mem[0] = 32'h0010_0093;   // addi x1,x0,1
        mem[1] = x2_init;         // addi x2,x0,{1|2}
        mem[2] = 32'h0000_0013;   // nop
        mem[3] = 32'h0000_0013;   // nop
        mem[4] = bne_word;        // at pc 0x10
    endtask

`ifdef RISCV_SEQ_BNE_EN
    task automatic test_bne();
        bit ok; int cyc; logic we; logic [4:0] wa; logic [31:0] wd;
        int n_ret;
        ack_delay = 0;
        // taken: x1=1, x2=2, bne x1,x2,-8
        load_branch_prog(32'h0020_0113, 32'hFE20_9CE3);
        do_reset();
        for (int i = 0; i < 5; i++) wait_retire(ok, cyc, we, wa, wd);
        checks++; if (!ok || we !== 1'b0) begin errors++; $display("FAIL bne_taken_retire got ok=%0d we=%b want 1/0", ok, we); end
        @(negedge clk);
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL bne_taken_pc got %h want 00000008", pc); end
        // not taken: x1=x2=1
        load_branch_prog(32'h0010_0113, 32'hFE20_9CE3);
        do_reset();
        for (int i = 0; i < 5; i++) wait_retire(ok, cyc, we, wa, wd);
        @(negedge clk);
        checks++; if (!ok || pc !== 32'h14) begin errors++; $display("FAIL bne_nottaken_pc got %h want 00000014", pc); end
        // taken to pc+6: misaligned target
        load_branch_prog(32'h0020_0113, 32'h0020_9363);
        do_reset();
        n_ret = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (retire) n_ret++;
        end
        checks++; if (n_ret != 4) begin errors++; $display("FAIL bne_mis_retires got %0d want 4", n_ret); end
        checks++; if (halted !== 1'b1 || fault !== 2'b10) begin errors++; $display("FAIL bne_mis_fault got %b/%b want 1/10", halted, fault); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL bne_mis_pc got %h want 00000010", pc); end
    endtask
`else
    task automatic test_bne_disabled();
        int n_ret = 0;
        ack_delay = 0;
        load_branch_prog(32'h0020_0113, 32'hFE20_9CE3);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (retire) n_ret++;
        end
        checks++; if (n_ret != 4) begin errors++; $display("FAIL bne_off_retires got %0d want 4", n_ret); end
        checks++; if (halted !== 1'b1 || fault !== 2'b01) begin errors++; $display("FAIL bne_off_fault got %b/%b want 1/01", halted, fault); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL bne_off_pc got %h want 00000010", pc); end
    endtask
`endif

    task automatic test_wait_states();
        bit ok; int cyc; logic we; logic [4:0] wa; logic [31:0] wd;
        bit addr_moved = 1'b0; int cyc2 = 0;
        ack_delay = 4;
        clear_mem();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'hFF90_8113;
        do_reset();
        wait_retire(ok, cyc, we, wa, wd);
        checks++; if (!ok || cyc != 7) begin errors++; $display("FAIL wait1_latency got ok=%0d cyc=%0d want 1/7", ok, cyc); end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr !== 32'h4) addr_moved = 1'b1;
            if (retire) begin cyc2 = i; wd = rf_wdata; break; end
        end
        checks++; if (addr_moved) begin errors++; $display("FAIL wait_addr_stable got moved=1 want 0"); end
        checks++; if (cyc2 != 7 || wd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wait2 got cyc=%0d d=%h want 7 fffffffe", cyc2, wd); end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok; int cyc; logic we; logic [4:0] wa; logic [31:0] wd;
        clear_mem();
        mem[0] = 32'h0050_0093;   // addi x1,x0,5
        manual = 1'b1;
        imem_ack = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        // reset with an ack carrying a different instruction in the same cycle
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h00A0_0093;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL rst_mid_req got req=%b pc=%h want 0 00000000", imem_req, pc); end
        reset = 1'b0;
        imem_ack = 1'b0;
        manual = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_restart got %b@%h want 1@00000000", imem_req, imem_addr); end
        wait_retire(ok, cyc, we, wa, wd);
        checks++; if (!ok || cyc != 2 || wd !== 32'd5) begin errors++; $display("FAIL rst_mid_drop got ok=%0d cyc=%0d d=%h want 1 2 00000005", ok, cyc, wd); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_addi_chain();
        test_addi_x0();
        test_illegal(32'h0000_0033, "illegal_op");
        test_illegal(32'h0000_0010, "illegal_quad");
`ifdef RISCV_SEQ_BNE_EN
        test_bne();
`else
        test_bne_disabled();
`endif
        test_wait_states();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
